// File: rtl/br_target_unit.sv
// Branch/jump target generator: PC + SEXT(offset) << ALIGN_SHIFT, base-register or PC pass-through.
// Latency 2 cycles (accept in N -> out_valid in N+2), one request per cycle sustained.
// Backpressure: two-entry valid/ready pipeline; in_ready follows out_ready combinationally; flush kills both stages.
module br_target_unit #(
  parameter int WIDTH       = 16,
  parameter int OFF_A_BITS  = 9,
  parameter int OFF_B_BITS  = 11,
  parameter int ALIGN_SHIFT = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] ir,
  input  logic [WIDTH-1:0] base_reg,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] target,
  output logic [1:0]       mode_out,
  output logic             wrap,
  output logic             misalign
);

  // Low ALIGN_SHIFT bits set; all zero when ALIGN_SHIFT is 0 so misalign can never fire.
  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_SHIFT) - WIDTH'(1);

  // Stage 1 state
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_pc;
  logic [WIDTH-1:0] r_s1_base;
  logic [WIDTH-1:0] r_s1_off;
  logic [1:0]       r_s1_mode;

  // Stage 2 state (drives the outputs directly)
  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_target;
  logic [1:0]       r_s2_mode;
  logic             r_s2_wrap;
  logic             r_s2_misalign;

  // Decode-side offset extraction
  logic [WIDTH-1:0] w_sext_a;
  logic [WIDTH-1:0] w_sext_b;
  logic [WIDTH-1:0] w_off_a;
  logic [WIDTH-1:0] w_off_b;
  logic [WIDTH-1:0] w_off_sel;
  logic             w_unused_ir;

  // Handshake
  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_accept;

  // Stage 2 datapath
  logic [WIDTH-1:0] w_sum;
  logic             w_is_add;
  logic             w_wrap;
  logic [WIDTH-1:0] w_target;
  logic             w_misalign;

  assign w_sext_a    = {{(WIDTH-OFF_A_BITS){ir[OFF_A_BITS-1]}}, ir[OFF_A_BITS-1:0]};
  assign w_sext_b    = {{(WIDTH-OFF_B_BITS){ir[OFF_B_BITS-1]}}, ir[OFF_B_BITS-1:0]};
  assign w_off_a     = w_sext_a << ALIGN_SHIFT;
  assign w_off_b     = w_sext_b << ALIGN_SHIFT;
  assign w_unused_ir = &{1'b0, ir[WIDTH-1:OFF_B_BITS]};

  // Offset select: only the PC-relative modes contribute an offset.
  always_comb begin
    w_off_sel = '0;
    case (mode)
      2'd0:    w_off_sel = w_off_a;
      2'd1:    w_off_sel = w_off_b;
      default: w_off_sel = '0;
    endcase
  end

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load && !flush;
  assign w_accept  = in_valid && in_ready;

  // Wrap is judged from the offset sign: a forward jump that lands below pc, or a
  // backward jump that lands above it, went around the address space.
  assign w_sum      = r_s1_pc + r_s1_off;
  assign w_is_add   = !r_s1_mode[1];
  assign w_wrap     = w_is_add && (r_s1_off[WIDTH-1] ? (w_sum > r_s1_pc) : (w_sum < r_s1_pc));
  assign w_target   = (r_s1_mode == 2'd2) ? r_s1_base : w_sum;
  assign w_misalign = (r_s1_mode == 2'd2) && (|(r_s1_base & ALIGN_MASK));

  // Stage 1: capture accepted request; flush drops whatever would be held.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_pc    <= '0;
      r_s1_base  <= '0;
      r_s1_off   <= '0;
      r_s1_mode  <= '0;
    end else begin
      if (flush) begin
        r_s1_valid <= 1'b0;
      end else if (w_s1_load) begin
        r_s1_valid <= in_valid;
      end
      if (w_accept) begin
        r_s1_pc   <= pc;
        r_s1_base <= base_reg;
        r_s1_off  <= w_off_sel;
        r_s1_mode <= mode;
      end
    end
  end

  // Stage 2: register the result; data only moves on a real transfer so outputs hold when stalled or empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid    <= 1'b0;
      r_s2_target   <= '0;
      r_s2_mode     <= '0;
      r_s2_wrap     <= 1'b0;
      r_s2_misalign <= 1'b0;
    end else begin
      if (flush) begin
        r_s2_valid <= 1'b0;
      end else if (w_s2_load) begin
        r_s2_valid <= r_s1_valid;
      end
      if (!flush && w_s2_load && r_s1_valid) begin
        r_s2_target   <= w_target;
        r_s2_mode     <= r_s1_mode;
        r_s2_wrap     <= w_wrap;
        r_s2_misalign <= w_misalign;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign target    = r_s2_target;
  assign mode_out  = r_s2_mode;
  assign wrap      = r_s2_wrap;
  assign misalign  = r_s2_misalign;

endmodule

// File: tb/tb_br_target_unit.sv
// Bench for br_target_unit: directed cases plus randomized traffic checked against a queue model.
// Model tracks accept cycle per entry to check latency, occupancy to check in_ready.
// Flush and async reset empty the model queue; deliveries in the flush cycle still count.
module tb_br_target_unit;

  localparam int W = 16;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  pc;
  logic [W-1:0]  ir;
  logic [W-1:0]  base_reg;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  target;
  logic [1:0]    mode_out;
  logic          wrap;
  logic          misalign;

  br_target_unit #(.WIDTH(16), .OFF_A_BITS(9), .OFF_B_BITS(11), .ALIGN_SHIFT(1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .ir(ir), .base_reg(base_reg), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .target(target), .mode_out(mode_out), .wrap(wrap), .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tgt;
    logic [1:0]  m;
    logic        w;
    logic        mis;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] dlv_tgt[$];
  logic        dlv_wrap[$];
  logic        dlv_mis[$];
  int          cyc;
  int          n_tests;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Reference: signed integer arithmetic on the offset field, wrap = result left 0..65535.
  function automatic exp_t ref_model(input logic [15:0] p, input logic [15:0] i,
                                     input logic [15:0] b, input logic [1:0] m);
    exp_t e;
    int   off;
    int   sum;
    off = 0;
    if (m == 2'd0) begin
      off = int'(i & 16'h01FF);
      if (off >= 256) off = off - 512;
    end else if (m == 2'd1) begin
      off = int'(i & 16'h07FF);
      if (off >= 1024) off = off - 2048;
    end
    off = off * 2;
    e.m   = m;
    e.acc = 0;
    if (m == 2'd2) begin
      e.tgt = b;
      e.w   = 1'b0;
      e.mis = (int'(b) % 2) != 0;
    end else begin
      sum   = int'(p) + off;
      e.w   = (m != 2'd3) && (sum < 0 || sum > 65535);
      e.tgt = 16'(((sum % 65536) + 65536) % 65536);
      e.mis = 1'b0;
    end
    return e;
  endfunction

  // One clock cycle: drive at negedge, check against model, update model at the edge.
  task automatic step(input logic iv, input logic [15:0] p, input logic [15:0] i,
                      input logic [15:0] b, input logic [1:0] m,
                      input logic ordy, input logic fl);
    logic exp_ov;
    logic exp_rdy;
    int   occ;
    exp_t e;
    @(negedge clk);
    in_valid  = iv;
    pc        = p;
    ir        = i;
    base_reg  = b;
    mode      = m;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_ov = (exp_q.size() > 0) && (cyc - exp_q[0].acc >= 2);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("target",   32'(target),   32'(exp_q[0].tgt));
      chk("mode_out", 32'(mode_out), 32'(exp_q[0].m));
      chk("wrap",     32'(wrap),     32'(exp_q[0].w));
      chk("misalign", 32'(misalign), 32'(exp_q[0].mis));
    end
    occ     = exp_q.size() - ((exp_ov && ordy) ? 1 : 0);
    exp_rdy = !fl && (occ < 2);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_ov && ordy) begin
      void'(exp_q.pop_front());
      dlv_tgt.push_back(target);
      dlv_wrap.push_back(wrap);
      dlv_mis.push_back(misalign);
    end
    if (iv && exp_rdy) begin
      e = ref_model(p, i, b, m);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    if (fl) exp_q.delete();
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 16'h0, 2'd0, ordy, 1'b0);
  endtask

  task automatic clr_dlv();
    dlv_tgt.delete();
    dlv_wrap.delete();
    dlv_mis.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_target"},    32'(target),    32'd0);
    chk({tag, "_mode_out"},  32'(mode_out),  32'd0);
    chk({tag, "_wrap"},      32'(wrap),      32'd0);
    chk({tag, "_misalign"},  32'(misalign),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc = '0; ir = '0; base_reg = '0; mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: BR backward by one word
    clr_dlv();
    step(1'b1, 16'h3000, 16'h01FF, 16'h0, 2'd0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t1_count", 32'(dlv_tgt.size()), 32'd1);
    if (dlv_tgt.size() == 1) begin
      chk("t1_target", 32'(dlv_tgt[0]), 32'h2FFE);
      chk("t1_wrap",   32'(dlv_wrap[0]), 32'd0);
    end

    // 2: JSR negative then positive, back-to-back
    clr_dlv();
    step(1'b1, 16'h3000, 16'h0600, 16'h0, 2'd1, 1'b1, 1'b0);
    step(1'b1, 16'h1000, 16'h00FF, 16'h0, 2'd1, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t2_count", 32'(dlv_tgt.size()), 32'd2);
    if (dlv_tgt.size() == 2) begin
      chk("t2_first",  32'(dlv_tgt[0]), 32'h2C00);
      chk("t2_second", 32'(dlv_tgt[1]), 32'h11FE);
    end

    // 3: base register (odd) and not-taken
    clr_dlv();
    step(1'b1, 16'h1234, 16'hFFFF, 16'h4001, 2'd2, 1'b1, 1'b0);
    step(1'b1, 16'h5000, 16'h01FF, 16'h0003, 2'd3, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t3_count", 32'(dlv_tgt.size()), 32'd2);
    if (dlv_tgt.size() == 2) begin
      chk("t3_base_tgt", 32'(dlv_tgt[0]),  32'h4001);
      chk("t3_base_mis", 32'(dlv_mis[0]),  32'd1);
      chk("t3_base_wrp", 32'(dlv_wrap[0]), 32'd0);
      chk("t3_nt_tgt",   32'(dlv_tgt[1]),  32'h5000);
      chk("t3_nt_mis",   32'(dlv_mis[1]),  32'd0);
    end

    // 4: wrap in both directions
    clr_dlv();
    step(1'b1, 16'hFFFE, 16'h0002, 16'h0, 2'd0, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 16'h01FF, 16'h0, 2'd0, 1'b1, 1'b0);
    idle(3, 1'b1);
    chk("t4_count", 32'(dlv_tgt.size()), 32'd2);
    if (dlv_tgt.size() == 2) begin
      chk("t4_up_tgt",  32'(dlv_tgt[0]),  32'h0002);
      chk("t4_up_wrp",  32'(dlv_wrap[0]), 32'd1);
      chk("t4_dn_tgt",  32'(dlv_tgt[1]),  32'hFFFE);
      chk("t4_dn_wrp",  32'(dlv_wrap[1]), 32'd1);
    end

    // 5: full pipeline under stall, then drain in order
    clr_dlv();
    step(1'b1, 16'h0100, 16'h0001, 16'h0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0200, 16'h0002, 16'h0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0300, 16'h0003, 16'h0, 2'd0, 1'b0, 1'b0);
    chk("t5_c_blocked", 32'(in_ready), 32'd0);
    idle(3, 1'b0);
    step(1'b1, 16'h0300, 16'h0003, 16'h0, 2'd0, 1'b1, 1'b0);
    idle(4, 1'b1);
    chk("t5_count", 32'(dlv_tgt.size()), 32'd3);
    if (dlv_tgt.size() == 3) begin
      chk("t5_a", 32'(dlv_tgt[0]), 32'h0102);
      chk("t5_b", 32'(dlv_tgt[1]), 32'h0204);
      chk("t5_c", 32'(dlv_tgt[2]), 32'h0306);
    end

    // 6a: flush with two entries in flight
    clr_dlv();
    step(1'b1, 16'h0400, 16'h0004, 16'h0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0500, 16'h0005, 16'h0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0600, 16'h0006, 16'h0, 2'd0, 1'b0, 1'b1);
    idle(3, 1'b1);
    chk("t6_flush_dlv", 32'(dlv_tgt.size()), 32'd0);

    // 6b: async reset mid-stream
    clr_dlv();
    step(1'b1, 16'h0700, 16'h0007, 16'h0, 2'd0, 1'b0, 1'b0);
    step(1'b1, 16'h0800, 16'h0008, 16'h0, 2'd0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk_reset_outputs("t6_rst");
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset_n = 1'b1;
    idle(3, 1'b1);
    chk("t6_rst_dlv", 32'(dlv_tgt.size()), 32'd0);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      step(($urandom_range(0, 9) < 7), 16'($urandom), 16'($urandom), 16'($urandom),
           2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));
    end
    idle(4, 1'b1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
